jtag_dbgreg: RTL and testbench
==============================

// Module: jtag_dbgreg
// PURPOSE
// - Debug data-register engine between the ECP5 JTAGG primitive and the SoC dbgreg port.
// - Oversamples JTAGG outputs in the system clock domain and shifts a DR_WIDTH data register on each jtck rise.
// - On Update-DR, delivers the register to the SoC as a 1-cycle strobe, with selector: 0 = IR 0x32 (JCE1), 1 = IR 0x38 (JCE2).
// - Optionally loads SoC data on capture and returns it on jtdo.
// PARAMETERS
// - DR_WIDTH     32  data register length in bits; 2..64
// - SYNC_STAGES  3   synchroniser depth on every J* input; >=2
// PORTS
// - clk            in   1         system clock (clk48m at top level)
// - rst            in   1         synchronous, active-high reset
// - jtck           in   1         JTAGG JTCK, asynchronous
// - jtdi           in   1         JTAGG JTDI
// - jshift         in   1         JTAGG JSHIFT
// - jupdate        in   1         JTAGG JUPDATE
// - jce1           in   1         JTAGG JCE1 (IR 0x32 capture/shift)
// - jce2           in   1         JTAGG JCE2 (IR 0x38 capture/shift)
// - jrstn          in   1         JTAGG JRSTN, active low
// - send_data      in   DR_WIDTH  SoC value loaded on capture (dbgreg_out of soc)
// - jtdo           out  1         data to JTAGG JTDO1/JTDO2
// - dbgreg_out     out  DR_WIDTH  last updated register (to soc dbgreg_in)
// - dbgreg_sel     out  1         0 = IR 0x32, 1 = IR 0x38
// - dbgreg_strobe  out  1         1-cycle pulse on update
// - len_err        out  1         last update shifted != DR_WIDTH bits
// BEHAVIOUR
// - Reset: rst=1 at a clk edge clears all state; all outputs 0; FSM IDLE; rst mid-shift loses the transfer, no strobe.
// - Sync: every J* input passes through SYNC_STAGES flops, all with equal delay.
// - Edges: rise = synced jtck 0->1; fall = synced jtck 1->0; each is a registered 1-cycle pulse.
// - All FSM events below occur only on rise cycles; other cycles hold state.
// - Synced jrstn=0 forces IDLE, clears shift reg/count/shift_q; dbgreg_out/sel/len_err hold; no strobe.
// - FSM IDLE
//   - On rise with synced (jce1|jce2): sel_q<=jce2; sr<=capture value; cnt<=0; go SHIFT.
// - FSM SHIFT
//   - On rise with shift_q=1: sr<={jtdi, sr[DR_WIDTH-1:1]} (LSB-first); cnt<=cnt+1, saturating at 2*DR_WIDTH-1.
//   - On every rise: shift_q<=synced jshift. shift_q is the jshift value from the previous rise.
//   - On rise with jupdate=1: go UPD; the update takes priority over jce/shift on the same rise.
//   - On rise with jce1|jce2: restart capture (sel_q, sr, cnt reload); stay in SHIFT.
// - FSM UPD, one cycle
//   - dbgreg_out<=sr; dbgreg_sel<=sel_q; len_err<=(cnt!=DR_WIDTH); dbgreg_strobe=1; go IDLE.
// - Latency: dbgreg_strobe high exactly SYNC_STAGES+2 clk after the first clk edge sampling jtck=1 with jupdate=1.
// - Strobe: single cycle; outputs stable from the strobe cycle until the next update.
// - Back-to-back updates need >= SYNC_STAGES+3 clk between jtck rises; jtck must be < clk/4.
// - Counter width: $clog2(2*DR_WIDTH); cannot wrap.
// CONFIGURATION
// - JTAG_DBG_TDO_EN defined:
//   - capture value = send_data.
//   - jtdo is a flop <= sr[0], updated on each fall cycle; 0 in IDLE/reset.
//   - A DR scan reads send_data LSB-first.
// - JTAG_DBG_TDO_EN undefined:
//   - capture value = 0.
//   - jtdo tied 0; send_data unused.
// TESTING
// - Shift 0xDEADBEEF LSB-first under jce1, then update -> dbgreg_out=0xDEADBEEF, sel=0, len_err=0, strobe 1 cycle at SYNC_STAGES+2 clk.
// - Same scan with jce2, data 0x12345678 -> dbgreg_out=0x12345678, sel=1; a second scan of 0x0 -> 0x0, sel=1.
// - Shift 31 bits, then update -> strobe=1, len_err=1; shift 40 bits -> len_err=1 and dbgreg_out = last 32 bits shifted.
// - Pulse jrstn low after 10 bits -> no strobe, dbgreg_out keeps its previous value; a following full scan works normally.
// - Assert rst mid-shift -> all outputs 0 on the next clk and no strobe; a new scan completes normally.
// - With JTAG_DBG_TDO_EN and send_data=0xA5A5A5A5: scan in 0x0 -> jtdo sequence 1,0,1,0,0,1,0,1,... and dbgreg_out=0x0.

Source files
------------

// File: rtl/jtag_dbgreg_if.sv
// jtag_dbgreg_if: JTAGG-side and SoC-side signals of the debug data-register engine
interface jtag_dbgreg_if #(parameter int DR_WIDTH = 32);
  logic jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn, jtdo;
  logic [DR_WIDTH-1:0] send_data, dbgreg_out;
  logic dbgreg_sel, dbgreg_strobe, len_err;
  modport master (
    output jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn, send_data,
    input  jtdo, dbgreg_out, dbgreg_sel, dbgreg_strobe, len_err
  );
  modport slave (
    input  jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn, send_data,
    output jtdo, dbgreg_out, dbgreg_sel, dbgreg_strobe, len_err
  );
endinterface

// File: rtl/jtag_dbgreg.sv
// jtag_dbgreg: oversampled JTAGG data-register engine with SoC update strobe
// JTAG_DBG_TDO_EN: capture send_data and shift it out on jtdo
module jtag_dbgreg #(
  parameter int DR_WIDTH    = 32,
  parameter int SYNC_STAGES = 3
) (
  input logic clk,
  input logic rst,
  jtag_dbgreg_if.slave bus
);
  localparam int CW = $clog2(2 * DR_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(2 * DR_WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, UPD} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0][6:0] sync;
  logic [6:0] q;
  logic rise, shift_q, sel_q, load, shift_en, upd;
  logic jtdi_s, jshift_s, jupd_s, jce1_s, jce2_s, jrstn_s, ce_s;
  logic [DR_WIDTH-1:0] sr, cap, out_q;
  logic [CW-1:0] cnt;
  logic sel_o, strobe_q, len_err_q;
  assign {jrstn_s, jce2_s, jce1_s, jupd_s, jshift_s, jtdi_s} = q[6:1];
  assign ce_s = jce1_s | jce2_s;
  // q trails the synchroniser by one flop so its data lines up with the registered rise pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      q    <= '0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], {bus.jrstn, bus.jce2, bus.jce1, bus.jupdate, bus.jshift, bus.jtdi, bus.jtck}};
      q    <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1][0] & ~q[0];
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb
    nxt = (!jrstn_s || state == UPD) ? IDLE :
          !rise                      ? state :
          state == IDLE              ? (ce_s ? SHIFT : IDLE) :
          jupd_s                     ? UPD : SHIFT;
  always_comb begin
    upd      = state == UPD && jrstn_s;
    load     = jrstn_s && rise && ce_s && (state == IDLE || (state == SHIFT && !jupd_s));
    shift_en = jrstn_s && rise && state == SHIFT && !jupd_s && !ce_s && shift_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      shift_q   <= 1'b0;
      sel_q     <= 1'b0;
      out_q     <= '0;
      sel_o     <= 1'b0;
      strobe_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      if (!jrstn_s) begin
        sr      <= '0;
        cnt     <= '0;
        shift_q <= 1'b0;
      end else begin
        if (rise) shift_q <= jshift_s;
        if (load) begin
          sel_q <= jce2_s;
          sr    <= cap;
          cnt   <= '0;
        end else if (shift_en) begin
          sr  <= {jtdi_s, sr[DR_WIDTH-1:1]};
          cnt <= cnt == CNT_MAX ? cnt : cnt + CW'(1);
        end
      end
      strobe_q <= upd;
      if (upd) begin
        out_q     <= sr;
        sel_o     <= sel_q;
        len_err_q <= cnt != CNT_FULL;
      end
    end
  end
`ifdef JTAG_DBG_TDO_EN
  logic fall, jtdo_q;
  always_ff @(posedge clk) begin
    fall   <= !rst && !sync[SYNC_STAGES-1][0] && q[0];
    jtdo_q <= (rst || state == IDLE || !jrstn_s) ? 1'b0 : fall ? sr[0] : jtdo_q;
  end
  assign cap      = bus.send_data;
  assign bus.jtdo = jtdo_q;
`else
  assign cap      = '0;
  assign bus.jtdo = 1'b0;
`endif
  assign bus.dbgreg_out    = out_q;
  assign bus.dbgreg_sel    = sel_o;
  assign bus.dbgreg_strobe = strobe_q;
  assign bus.len_err       = len_err_q;
endmodule

// File: tb/tb_jtag_dbgreg.sv
// tb_jtag_dbgreg: randomized scans of jtag_dbgreg checked against a bit-queue model
module tb_jtag_dbgreg;
  localparam int DW   = 32;
  localparam int SS   = 3;
  localparam int HALF = 6;
`ifdef JTAG_DBG_TDO_EN
  localparam bit TDO_EN = 1'b1;
`else
  localparam bit TDO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  jtag_dbgreg_if #(.DR_WIDTH(DW)) bus ();
  jtag_dbgreg #(.DR_WIDTH(DW), .SYNC_STAGES(SS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // register after a scan = last DW entries of (capture bits LSB-first, then shifted bits)
  function automatic logic [DW-1:0] model(input logic [DW-1:0] cap, input logic [63:0] data, input int n);
    logic bits[$];
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) bits.push_back(cap[i]);
    for (int i = 0; i < n; i++) bits.push_back(data[i]);
    for (int k = 0; k < DW; k++) r[k] = bits[bits.size() - DW + k];
    return r;
  endfunction

  task automatic jcyc(input logic tdi, input logic sh, input logic up, input logic c1, input logic c2, output logic tdo);
    bus.jtck = 1'b0;
    bus.jtdi = tdi;
    bus.jshift = sh;
    bus.jupdate = up;
    bus.jce1 = c1;
    bus.jce2 = c2;
    repeat (HALF) @(posedge clk);
    #1 tdo = bus.jtdo;
    bus.jtck = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  // lat = clk edges from the edge that first samples jtck=1 to the strobe edge
  task automatic do_update(output int lat, output int hits);
    bus.jtck = 1'b0;
    bus.jupdate = 1'b1;
    bus.jshift = 1'b0;
    bus.jce1 = 1'b0;
    bus.jce2 = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 bus.jtck = 1'b1;
    lat = -1;
    hits = 0;
    for (int k = 1; k <= 3 * HALF; k++) begin
      @(posedge clk);
      #1;
      if (bus.dbgreg_strobe) begin
        hits++;
        if (lat < 0) lat = k - 1;
      end
      if (k == HALF) begin
        bus.jtck = 1'b0;
        bus.jupdate = 1'b0;
      end
    end
  endtask

  task automatic run_scan(input string nm, input logic c2, input logic [63:0] data, input int n);
    logic [DW-1:0] exp;
    logic t;
    int lat, hits;
    exp = model(TDO_EN ? bus.send_data : '0, data, n);
    jcyc(1'b0, n > 0, 1'b0, !c2, c2, t);
    for (int i = 1; i <= n; i++) jcyc(data[i-1], i < n, 1'b0, 1'b0, 1'b0, t);
    do_update(lat, hits);
    checks++;
    if (hits !== 1) begin errors++; $display("FAIL %s strobe_count: got %0d expected 1", nm, hits); end
    checks++;
    if (lat !== SS + 2) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, SS + 2); end
    checks++;
    if (bus.dbgreg_out !== exp) begin errors++; $display("FAIL %s dbgreg_out: got %h expected %h", nm, bus.dbgreg_out, exp); end
    checks++;
    if (bus.dbgreg_sel !== c2) begin errors++; $display("FAIL %s dbgreg_sel: got %b expected %b", nm, bus.dbgreg_sel, c2); end
    checks++;
    if (bus.len_err !== (n != DW)) begin errors++; $display("FAIL %s len_err: got %b expected %b", nm, bus.len_err, n != DW); end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({bus.dbgreg_out, bus.dbgreg_sel, bus.dbgreg_strobe, bus.len_err, bus.jtdo} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got out=%h sel=%b strobe=%b len_err=%b jtdo=%b expected all 0", nm,
               bus.dbgreg_out, bus.dbgreg_sel, bus.dbgreg_strobe, bus.len_err, bus.jtdo);
    end
  endtask

  task automatic test_reset;
    {bus.jtck, bus.jtdi, bus.jshift, bus.jupdate, bus.jce1, bus.jce2} = '0;
    bus.jrstn = 1'b1;
    bus.send_data = $urandom;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_jce1;
    bus.send_data = $urandom;
    run_scan("jce1_deadbeef", 1'b0, 64'hDEADBEEF, DW);
  endtask

  task automatic test_jce2;
    bus.send_data = $urandom;
    run_scan("jce2_12345678", 1'b1, 64'h12345678, DW);
    run_scan("jce2_zero", 1'b1, 64'h0, DW);
  endtask

  task automatic test_length;
    bus.send_data = $urandom;
    run_scan("short31", 1'b0, {$urandom, $urandom}, DW - 1);
    run_scan("long40", 1'b1, {$urandom, $urandom}, DW + 8);
  endtask

  task automatic test_jrstn;
    logic [DW-1:0] prev;
    logic t;
    int lat, hits;
    run_scan("pre_jrstn", 1'b0, {32'h0, $urandom | 32'h1}, DW);
    prev = bus.dbgreg_out;
    jcyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t);
    for (int i = 1; i <= 10; i++) jcyc($urandom_range(1), 1'b1, 1'b0, 1'b0, 1'b0, t);
    bus.jrstn = 1'b0;
    repeat (2) jcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, t);
    bus.jrstn = 1'b1;
    jcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    do_update(lat, hits);
    checks++;
    if (hits !== 0) begin errors++; $display("FAIL jrstn_strobe: got %0d expected 0", hits); end
    checks++;
    if (bus.dbgreg_out !== prev) begin errors++; $display("FAIL jrstn_hold: got %h expected %h", bus.dbgreg_out, prev); end
    run_scan("post_jrstn", 1'b1, {$urandom, $urandom}, DW);
  endtask

  task automatic test_rst_mid;
    logic t;
    int lat, hits;
    run_scan("pre_rst", 1'b1, {32'h0, $urandom | 32'h1}, DW);
    jcyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t);
    for (int i = 1; i <= 10; i++) jcyc($urandom_range(1), 1'b1, 1'b0, 1'b0, 1'b0, t);
    bus.jtck = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check_zero("rst_mid");
    rst = 1'b0;
    do_update(lat, hits);
    checks++;
    if (hits !== 0) begin errors++; $display("FAIL rst_mid_strobe: got %0d expected 0", hits); end
    run_scan("post_rst", 1'b0, {$urandom, $urandom}, DW);
  endtask

  task automatic test_tdo;
    logic [DW-1:0] seq, exp;
    logic t;
    int lat, hits;
    bus.send_data = 32'hA5A5A5A5;
    exp = TDO_EN ? 32'hA5A5A5A5 : 32'h0;
    jcyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t);
    for (int i = 1; i <= DW; i++) begin
      jcyc(1'b0, i < DW, 1'b0, 1'b0, 1'b0, t);
      seq[i-1] = t;
    end
    checks++;
    if (seq !== exp) begin errors++; $display("FAIL tdo_sequence: got %h expected %h (LSB first)", seq, exp); end
    do_update(lat, hits);
    checks++;
    if (bus.dbgreg_out !== '0) begin errors++; $display("FAIL tdo_out: got %h expected 0", bus.dbgreg_out); end
    checks++;
    if (hits !== 1) begin errors++; $display("FAIL tdo_strobe: got %0d expected 1", hits); end
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 8; r++) begin
      bus.send_data = $urandom;
      n = (r % 2 == 0) ? DW : $urandom_range(DW + 3, DW - 3);
      run_scan($sformatf("rand%0d", r), $urandom_range(1), {$urandom, $urandom}, n);
    end
  endtask

  task automatic test_back_to_back;
    bus.send_data = $urandom;
    run_scan("b2b_a", 1'b0, {$urandom, $urandom}, DW);
    run_scan("b2b_b", 1'b1, {$urandom, $urandom}, DW);
  endtask

  initial begin
    test_reset;
    test_jce1;
    test_jce2;
    test_length;
    test_jrstn;
    test_rst_mid;
    test_tdo;
    test_random;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
